// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
//   requesters. It picks the next requester after the last winner, latches
//   that requester's byte, and pulses Data_Valid. It then waits for the
//   transmitter's busy flag to rise and fall before it arbitrates again.
//
// Ports
//   CLK            clock (UART TX domain)
//   RST            synchronous, active-high reset
//   REQ            per-requester request level; held until ACK
//   REQ_DATA       packed bytes; byte i is at [i*DATA_WIDTH +: DATA_WIDTH]
//   ACK            one-hot, single-cycle pulse: the requester's byte has been consumed
//   TX_P_DATA      byte sent to the UART; holds its value between frames
//   TX_DATA_VALID  single-cycle Data_Valid pulse to the UART
//   TX_BUSY        busy flag from the UART
//   ERR            single-cycle pulse: TX_BUSY did not rise in time, frame abandoned
//
// Build option
//   UART_ARB_HDR_EN: each granted byte is preceded by a header byte that
//   carries the requester index.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            ACK,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic                          TX_DATA_VALID,
    input  logic                          TX_BUSY,
    output logic                          ERR
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef UART_ARB_HDR_EN
        S_HDR,
`endif
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        sel_q, sel_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
`ifdef UART_ARB_HDR_EN
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hdr_ph_q, hdr_ph_d;   // current frame is the header
`endif

    logic [PTR_W-1:0]        win;
    logic                    win_vld;
    logic [PTR_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   win_data;

    // Scan ptr+1, ptr+2, ... and wrap by an explicit compare, so a NUM_REQ
    // that is not a power of two never lands on an index that does not exist.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
            if (!win_vld && REQ[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign win_data = REQ_DATA[int'(win)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        tx_data_d     = tx_data_q;
        tmo_cnt_d     = tmo_cnt_q;
`ifdef UART_ARB_HDR_EN
        hold_d        = hold_q;
        hdr_ph_d      = hdr_ph_q;
`endif
        ACK           = '0;
        TX_DATA_VALID = 1'b0;
        ERR           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_vld && !TX_BUSY) begin
                    sel_d = win;
                    ptr_d = win;
`ifdef UART_ARB_HDR_EN
                    tx_data_d = DATA_WIDTH'(win);
                    hold_d    = win_data;
                    hdr_ph_d  = 1'b1;
                    state_d   = S_HDR;
`else
                    tx_data_d = win_data;
                    state_d   = S_SEND;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            S_HDR: begin
                TX_DATA_VALID = 1'b1;
                tmo_cnt_d     = '0;
                state_d       = S_WAIT_BUSY;
            end
`endif
            S_SEND: begin
                TX_DATA_VALID = 1'b1;
                ACK[sel_q]    = 1'b1;
                tmo_cnt_d     = '0;
                state_d       = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // The UART never accepted the frame. In the plain build the
                    // byte has already been acknowledged. A header timeout leaves
                    // the request pending.
                    ERR     = 1'b1;
                    state_d = S_IDLE;
`ifdef UART_ARB_HDR_EN
                    hdr_ph_d = 1'b0;
`endif
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!TX_BUSY) begin
`ifdef UART_ARB_HDR_EN
                    if (hdr_ph_q) begin
                        tx_data_d = hold_q;
                        hdr_ph_d  = 1'b0;
                        state_d   = S_SEND;
                    end else begin
                        state_d   = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            ptr_q     <= LAST_IDX;   // requester 0 wins first
            tx_data_q <= '0;
            tmo_cnt_q <= '0;
`ifdef UART_ARB_HDR_EN
            hold_q    <= '0;
            hdr_ph_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            tmo_cnt_q <= tmo_cnt_d;
`ifdef UART_ARB_HDR_EN
            hold_q    <= hold_d;
            hdr_ph_q  <= hdr_ph_d;
`endif
        end
    end

    assign TX_P_DATA = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, 8-bit bytes, timeout 16).
// A small behavioural model of the UART raises busy one cycle after
// Data_Valid and holds it for 10 cycles. The model can be switched off to
// provoke a timeout.
module tb_uart_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ;
    logic [31:0] REQ_DATA;
    logic [3:0]  ACK;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        TX_BUSY;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 1'b1;
    int busy_left = 0;

    uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .ACK(ACK),
        .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
        .TX_BUSY(TX_BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (model_on && TX_DATA_VALID) busy_left <= 10;
        else if (busy_left > 0)        busy_left <= busy_left - 1;
    end
    assign TX_BUSY = (busy_left != 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sig_of(input int what);
        case (what)
            0:       return TX_DATA_VALID;
            1:       return ERR;
            default: return !TX_BUSY;
        endcase
    endfunction

    // Wait on negedges until the selected event occurs. n is the number of
    // negedges waited. An expired bound counts as a failed comparison.
    task automatic wait_for(input string tag, input int what, input int bound, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!sig_of(what) && n < bound);
        if (!sig_of(what)) chk({tag, "_timeout"}, 32'(sig_of(what)), 1);
    endtask

    initial begin
        int n;
        int cnt;
        RST      = 1'b1;
        REQ      = 4'b1111;
        REQ_DATA = 32'h13121110;

        // T1: reset held 3 cycles with all requests pending
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t1_rst_ack", 32'(ACK), 0);
            chk("t1_rst_vld", 32'(TX_DATA_VALID), 0);
            chk("t1_rst_err", 32'(ERR), 0);
        end
        RST = 1'b0;

`ifndef UART_ARB_HDR_EN
        wait_for("t1_vld", 0, 40, n);
        chk("t1_lat", n, 1);
        chk("t1_ack", 32'(ACK), 32'h1);
        chk("t1_data", 32'(TX_P_DATA), 32'h10);

        // T3: continuous requests rotate 1,2,3,0 after the first grant
        for (int i = 1; i <= 4; i++) begin
            wait_for("t3_vld", 0, 40, n);
            chk("t3_gap", n, 13);
            chk("t3_ack", 32'(ACK), 32'(4'b0001 << (i % 4)));
            chk("t3_data", 32'(TX_P_DATA), 32'h10 + 32'(i % 4));
            chk("t3_notbusy", 32'(TX_BUSY), 0);
        end
        REQ = 4'b0000;

        // T2: single requester; it keeps requesting after ACK to show no valid while busy
        wait_for("t2_idle", 2, 40, n);
        REQ_DATA[23:16] = 8'hA5;
        REQ = 4'b0100;
        wait_for("t2_vld", 0, 40, n);
        chk("t2_ack", 32'(ACK), 32'h4);
        chk("t2_data", 32'(TX_P_DATA), 32'hA5);
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            if (TX_DATA_VALID || (ACK != 0)) cnt++;
        end
        chk("t2_quiet_busy", cnt, 0);
        wait_for("t2_vld2", 0, 10, n);
        chk("t2_gap2", n, 2);
        chk("t2_ack2", 32'(ACK), 32'h4);
        REQ = 4'b0000;
        wait_for("t2_idle2", 2, 40, n);
        repeat (3) @(negedge CLK);
        chk("t2_hold", 32'(TX_P_DATA), 32'hA5);

        // T4: UART never asserts busy; ptr=2, so requester 0 comes before 1
        model_on = 1'b0;
        REQ = 4'b0011;
        wait_for("t4_vld", 0, 20, n);
        chk("t4_ack", 32'(ACK), 32'h1);
        chk("t4_data", 32'(TX_P_DATA), 32'h10);
        REQ = 4'b0010;
        wait_for("t4_err", 1, 40, n);
        chk("t4_err_lat", n, 16);
        wait_for("t4_vld2", 0, 10, n);
        chk("t4_regrant", n, 2);
        chk("t4_ack2", 32'(ACK), 32'h2);
        chk("t4_data2", 32'(TX_P_DATA), 32'h11);
        REQ = 4'b0000;
        wait_for("t4_err2", 1, 40, n);
        chk("t4_err2_lat", n, 16);
        model_on = 1'b1;
        repeat (2) @(negedge CLK);

        // T5: reset during WAIT_DONE; the pointer must return to its reset value
        REQ = 4'b0100;
        wait_for("t5_vld", 0, 20, n);
        chk("t5_ack", 32'(ACK), 32'h4);
        REQ = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("t5_inframe", 32'(TX_BUSY), 1);
        RST = 1'b1;
        REQ = 4'b1111;
        @(negedge CLK);
        chk("t5_rst_vld", 32'(TX_DATA_VALID), 0);
        chk("t5_rst_ack", 32'(ACK), 0);
        chk("t5_rst_err", 32'(ERR), 0);
        RST = 1'b0;
        wait_for("t5_vld2", 0, 30, n);
        chk("t5_ack2", 32'(ACK), 32'h1);
        chk("t5_data2", 32'(TX_P_DATA), 32'h10);
        REQ = 4'b0000;
        wait_for("t5_idle", 2, 40, n);
`else
        // Header build: the first grant is requester 0. Header 00 comes first, then data 10.
        wait_for("h1_vld", 0, 40, n);
        chk("h1_hdr", 32'(TX_P_DATA), 32'h00);
        chk("h1_hdr_ack", 32'(ACK), 0);
        wait_for("h1_vld2", 0, 40, n);
        chk("h1_data", 32'(TX_P_DATA), 32'h10);
        chk("h1_ack", 32'(ACK), 32'h1);
        REQ = 4'b0000;
        wait_for("h1_idle", 2, 40, n);
        repeat (2) @(negedge CLK);

        // T6: requester 3 gets header 03, then 5A with the only ACK
        REQ_DATA[31:24] = 8'h5A;
        REQ = 4'b1000;
        wait_for("t6_vld", 0, 40, n);
        chk("t6_hdr", 32'(TX_P_DATA), 32'h03);
        chk("t6_hdr_ack", 32'(ACK), 0);
        wait_for("t6_vld2", 0, 40, n);
        chk("t6_data", 32'(TX_P_DATA), 32'h5A);
        chk("t6_ack", 32'(ACK), 32'h8);
        REQ = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (ACK != 0) cnt++;
        end
        chk("t6_one_ack", cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
